// File: rtl/mux8_scan_pkg.sv
// Shared types and constants for the mux8 scan controller.
package mux8_scan_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } scan_state_e;

  localparam int unsigned SEL_W_DEF = 3;
  localparam int unsigned DWELL_W   = 8;

endpackage

// File: rtl/scan_dwell_timer.sv
// Dwell timer: counts 0..DWELL-1 while not cleared, ticking on the last count.
module scan_dwell_timer
  import mux8_scan_pkg::*;
#(
  parameter int unsigned DWELL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick_out
);

  logic [DWELL_W-1:0] count_q, count_d;

  assign tick_out = (count_q == DWELL_W'(DWELL - 1));

  always_comb begin
    count_d = count_q + DWELL_W'(1);
    if (clear || tick_out) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mux8_scan_ctrl.sv
// Scans select_line over all mux channels, captures mux_y per channel and publishes the word
// atomically with a done pulse. Optional registered parity output under SCAN_PARITY_EN.
module mux8_scan_ctrl
  import mux8_scan_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_W_DEF,
  parameter int unsigned DWELL = 1,
  localparam int unsigned N_CH = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             mux_y,
  output logic [SEL_W-1:0] select_line,
  output logic             busy,
  output logic [N_CH-1:0]  data_out,
  output logic             done
`ifdef SCAN_PARITY_EN
  ,
  output logic             parity
`endif
);

  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_CH-1:0]  capture_q, capture_d;
  logic [N_CH-1:0]  data_q, data_d;
  logic             done_q, done_d;
  logic             tick;

  scan_dwell_timer #(
    .DWELL (DWELL)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_q != S_SCAN),
    .tick_out (tick)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    capture_d = capture_q;
    data_d    = data_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          sel_d   = '0;
        end
      end
      S_SCAN: begin
        if (tick) begin
          capture_d[sel_q] = mux_y;
          sel_d            = sel_q + SEL_W'(1);
          // Last channel: publish directly from mux_y so the word is complete this edge.
          if (sel_q == SEL_W'(N_CH - 1)) begin
            data_d  = {mux_y, capture_q[N_CH-2:0]};
            done_d  = 1'b1;
            state_d = continuous ? S_SCAN : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      capture_q <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      capture_q <= capture_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

`ifdef SCAN_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^data_d;
    end
  end

  assign parity = parity_q;
`endif

  assign select_line = sel_q;
  assign busy        = (state_q == S_SCAN);
  assign data_out    = data_q;
  assign done        = done_q;

endmodule
